// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front end sampling SS_n/MOSI on clk. Receives
// 10-bit frames {cmd[1:0], payload[7:0]} MSB first, strobes them to the RAM,
// and serialises a read byte back on MISO after a read-data frame.
// Optional feature: define SPI_FRAME_ERR_EN to add the frame_err output,
// a one-cycle pulse when SS_n rises before a frame's last bit was sampled.
module spi_slave_if (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  localparam int unsigned RX_W  = 10;
  localparam int unsigned TX_W  = 8;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RX_W-2:0]     rx_shift_q, rx_shift_d;
  logic                done_q, done_d;
  logic                rd_addr_seen_q, rd_addr_seen_d;
  logic                armed_q, armed_d;
  logic [RX_W-1:0]     rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic [TX_W-1:0]     tx_shift_q, tx_shift_d;
  logic                tx_loaded_q, tx_loaded_d;
  logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic                miso_q, miso_d;
`ifdef SPI_FRAME_ERR_EN
  logic                frame_err_q, frame_err_d;
`endif

  // Next-state, frame assembly and read-byte serialisation.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rx_shift_d     = rx_shift_q;
    done_d         = done_q;
    rd_addr_seen_d = rd_addr_seen_q;
    armed_d        = armed_q | SS_n;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    tx_shift_d     = tx_shift_q;
    tx_loaded_d    = tx_loaded_q;
    tx_cnt_d       = tx_cnt_q;
    miso_d         = 1'b0;
`ifdef SPI_FRAME_ERR_EN
    frame_err_d    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d       = '0;
        done_d      = 1'b0;
        rx_shift_d  = '0;
        tx_shift_d  = '0;
        tx_loaded_d = 1'b0;
        tx_cnt_d    = '0;
        // armed_q demands SS_n was seen high since reset: a fresh select only
        if (!SS_n && armed_q) state_d = CHK_CMD;
      end

      CHK_CMD: begin
        if (SS_n) begin
          state_d = IDLE;
`ifdef SPI_FRAME_ERR_EN
          frame_err_d = 1'b1;
`endif
        end else begin
          rx_shift_d = {(RX_W-2)'(0), MOSI};
          cnt_d      = CNT_W'(RX_W - 2);
          if (!MOSI)               state_d = WRITE;
          else if (rd_addr_seen_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
      end

      WRITE, READ_ADD, READ_DATA: begin
        if (!done_q) begin
          // Bit 0 completes the frame even if SS_n rises on the same edge
          if (cnt_q == '0) begin
            rx_data_d  = {rx_shift_q, MOSI};
            rx_valid_d = 1'b1;
            done_d     = 1'b1;
            if (state_q == READ_ADD)  rd_addr_seen_d = 1'b1;
            if (state_q == READ_DATA) rd_addr_seen_d = 1'b0;
          end else if (SS_n) begin
`ifdef SPI_FRAME_ERR_EN
            frame_err_d = 1'b1;
`endif
          end else begin
            rx_shift_d = {rx_shift_q[RX_W-3:0], MOSI};
            cnt_d      = cnt_q - CNT_W'(1);
          end
        end

        // Read byte: load once on tx_valid, then shift out MSB first
        if (state_q == READ_DATA && done_q) begin
          if (!tx_loaded_q && tx_valid) begin
            tx_shift_d  = tx_data;
            tx_loaded_d = 1'b1;
            tx_cnt_d    = CNT_W'(TX_W);
          end else if (tx_cnt_q != '0) begin
            miso_d     = tx_shift_q[TX_W-1];
            tx_shift_d = {tx_shift_q[TX_W-2:0], 1'b0};
            tx_cnt_d   = tx_cnt_q - CNT_W'(1);
          end
        end

        if (SS_n) begin
          state_d     = IDLE;
          cnt_d       = '0;
          done_d      = 1'b0;
          rx_shift_d  = '0;
          tx_shift_d  = '0;
          tx_loaded_d = 1'b0;
          tx_cnt_d    = '0;
          miso_d      = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rx_shift_q     <= '0;
      done_q         <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      armed_q        <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      tx_shift_q     <= '0;
      tx_loaded_q    <= 1'b0;
      tx_cnt_q       <= '0;
      miso_q         <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rx_shift_q     <= rx_shift_d;
      done_q         <= done_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      armed_q        <= armed_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      tx_shift_q     <= tx_shift_d;
      tx_loaded_q    <= tx_loaded_d;
      tx_cnt_q       <= tx_cnt_d;
      miso_q         <= miso_d;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q    <= frame_err_d;
`endif
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`ifdef SPI_FRAME_ERR_EN
  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed frames for spi_slave_if. Received words and
// cycle-stamped signal expectations go into queues; a negedge monitor pops
// and compares them against the DUT outputs.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  spi_slave_if dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  localparam int S_MISO = 0, S_RXV = 1, S_RXD = 2, S_STATE = 3, S_RDSEEN = 4, S_FERR = 5;
  localparam int ST_IDLE = 0, ST_WRITE = 2, ST_RADD = 3, ST_RDATA = 4;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } exp_t;

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [9:0] rx_q[$];
  exp_t       exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sig_name(input int s);
    case (s)
      S_MISO:   return "MISO";
      S_RXV:    return "rx_valid";
      S_RXD:    return "rx_data";
      S_STATE:  return "state";
      S_RDSEEN: return "rd_addr_seen";
      default:  return "frame_err";
    endcase
  endfunction

  function automatic int sig_val(input int s);
    case (s)
      S_MISO:   return int'(MISO);
      S_RXV:    return int'(rx_valid);
      S_RXD:    return int'(rx_data);
      S_STATE:  return int'(dut.state_q);
      S_RDSEEN: return int'(dut.rd_addr_seen_q);
`ifdef SPI_FRAME_ERR_EN
      S_FERR:   return int'(frame_err);
`endif
      default:  return 0;
    endcase
  endfunction

  // Monitor: frame words on every rx_valid, timed expectations on their cycle
  always @(negedge clk) begin
    if (rx_valid) begin
      checks = checks + 1;
      if (rx_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL rx_word cyc=%0d unexpected rx_valid, rx_data=%03h", cyc, rx_data);
      end else begin
        logic [9:0] w;
        w = rx_q.pop_front();
        if (rx_data !== w) begin
          errors = errors + 1;
          $display("FAIL rx_word cyc=%0d got=%03h exp=%03h", cyc, rx_data, w);
        end
      end
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        int v;
        v = sig_val(exp_q[i].sig);
        checks = checks + 1;
        if (v != exp_q[i].val) begin
          errors = errors + 1;
          $display("FAIL %s cyc=%0d got=%0h exp=%0h", sig_name(exp_q[i].sig), cyc, v, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic expect_at(input int c, input int s, input int v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Drive inputs, then let one rising edge sample them
  task automatic step(input logic ss, input logic mosi, input logic txv);
    SS_n     = ss;
    MOSI     = mosi;
    tx_valid = txv;
    @(posedge clk);
    #2;
  endtask

  // Select, then send the first nbits of w MSB first; SS_n optionally rises with the last bit
  task automatic run_frame(input logic [9:0] w, input int nbits, input bit ss_last,
                           input logic txv, input int st_exp);
    step(1'b0, 1'b0, txv);
    for (int i = 0; i < nbits; i++) begin
      logic ss;
      ss = (ss_last && (i == nbits - 1)) ? 1'b1 : 1'b0;
      step(ss, w[9-i], txv);
      if (i == 0) begin
        expect_at(cyc, S_STATE, st_exp);
        expect_at(cyc, S_MISO, 0);
      end
    end
    if (nbits == 10) rx_q.push_back(w);
  endtask

  initial begin
    logic [7:0] rd_bits;
    int k;
    rd_bits = 8'b1001_0110;

    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    expect_at(cyc, S_STATE, ST_IDLE);
    expect_at(cyc, S_RXD, 0);
    expect_at(cyc, S_RXV, 0);
    expect_at(cyc, S_MISO, 0);
    step(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);

    // Write-address frame with tx_valid held high (must be ignored)
    tx_data = 8'hFF;
    run_frame(10'b00_1010_0101, 10, 1'b0, 1'b1, ST_WRITE);
    expect_at(cyc, S_RDSEEN, 0);
    expect_at(cyc, S_MISO, 0);
    expect_at(cyc + 1, S_RXV, 0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    expect_at(cyc, S_STATE, ST_IDLE);
    step(1'b1, 1'b0, 1'b0);

    // Write-data frame
    run_frame(10'b01_0011_1100, 10, 1'b0, 1'b0, ST_WRITE);
    step(1'b1, 1'b0, 1'b0);

    // Read-address frame
    run_frame(10'b10_0000_0111, 10, 1'b0, 1'b0, ST_RADD);
    expect_at(cyc, S_RDSEEN, 1);
    step(1'b1, 1'b0, 1'b0);

    // Read-data frame, then byte 0x96 on MISO; a second tx_valid is ignored
    tx_data = 8'h96;
    run_frame(10'b11_0101_1010, 10, 1'b0, 1'b0, ST_RDATA);
    k = cyc;
    expect_at(k, S_RDSEEN, 0);
    step(1'b0, 1'b0, 1'b1);
    expect_at(k + 1, S_MISO, 0);
    for (int b = 0; b < 8; b++) expect_at(k + 2 + b, S_MISO, int'(rd_bits[7-b]));
    expect_at(k + 10, S_MISO, 0);
    tx_data = 8'h00;
    step(1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 9; j++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    expect_at(cyc, S_STATE, ST_IDLE);
    expect_at(cyc, S_MISO, 0);
    step(1'b1, 1'b0, 1'b0);

    // Aborted read-address frame after 5 bits
    run_frame(10'b10_1100_0000, 5, 1'b0, 1'b0, ST_RADD);
    step(1'b1, 1'b0, 1'b0);
    expect_at(cyc, S_STATE, ST_IDLE);
    expect_at(cyc, S_RDSEEN, 0);
    expect_at(cyc, S_RXV, 0);
`ifdef SPI_FRAME_ERR_EN
    expect_at(cyc, S_FERR, 1);
    expect_at(cyc + 1, S_FERR, 0);
`endif
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Arm rd_addr_seen, then reset during bit 4 of a new frame
    run_frame(10'b10_1010_1010, 10, 1'b0, 1'b0, ST_RADD);
    expect_at(cyc, S_RDSEEN, 1);
    step(1'b1, 1'b0, 1'b0);
    run_frame(10'b00_1111_0000, 5, 1'b0, 1'b0, ST_WRITE);
    SS_n = 1'b0; MOSI = 1'b1;
    rst_n = 1'b0;
    expect_at(cyc, S_STATE, ST_IDLE);
    expect_at(cyc, S_RXD, 0);
    expect_at(cyc, S_RXV, 0);
    expect_at(cyc, S_MISO, 0);
    expect_at(cyc, S_RDSEEN, 0);
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    expect_at(cyc, S_STATE, ST_IDLE);
    step(1'b1, 1'b0, 1'b0);
    run_frame(10'b00_0000_0001, 10, 1'b0, 1'b0, ST_WRITE);
    step(1'b1, 1'b0, 1'b0);
    run_frame(10'b11_0000_0000, 1, 1'b0, 1'b0, ST_RADD);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // SS_n rises on the edge sampling bit 0
    run_frame(10'b01_0101_0101, 10, 1'b1, 1'b0, ST_WRITE);
    expect_at(cyc, S_STATE, ST_IDLE);
    expect_at(cyc, S_RXV, 1);
`ifdef SPI_FRAME_ERR_EN
    expect_at(cyc, S_FERR, 0);
`endif
    expect_at(cyc + 1, S_RXV, 0);
    for (int j = 0; j < 4; j++) step(1'b1, 1'b0, 1'b0);

    checks = checks + 1;
    if (rx_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL rx_pending got=%0d words left exp=0", rx_q.size());
    end
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL exp_pending got=%0d entries left exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
SPI_SLAVE_IF -- requirements
Module: spi_slave_if

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have the port SS_n, input, 1 bit: active-low slave select, framing one transaction.
REQ-004 The block SHALL have the port MOSI, input, 1 bit: serial data in, MSB first.
REQ-005 The block SHALL have the port MISO, output, 1 bit: serial read data out, MSB first.
REQ-006 The block SHALL have the port rx_data, output, 10 bits: assembled frame {cmd[1:0], payload[7:0]} to the RAM.
REQ-007 The block SHALL have the port rx_valid, output, 1 bit: one-cycle strobe marking rx_data valid.
REQ-008 The block SHALL have the port tx_data, input, 8 bits: read byte returned by the RAM.
REQ-009 The block SHALL have the port tx_valid, input, 1 bit: qualifies tx_data.

Function
REQ-010 The FSM SHALL have the states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA, plus an internal flag rd_addr_seen.
REQ-011 In IDLE, SS_n=0 SHALL move the FSM to CHK_CMD on the next edge, and SS_n=1 SHALL keep it in IDLE.
REQ-012 In CHK_CMD, the MOSI bit sampled SHALL be stored as rx bit 9, and the next state SHALL be WRITE if it is 0, READ_ADD if it is 1 with rd_addr_seen=0, and READ_DATA if it is 1 with rd_addr_seen=1.
REQ-013 In WRITE, READ_ADD and READ_DATA, the block SHALL shift in bits 8..0, one per edge, using a 4-bit bit counter.
REQ-014 At the edge sampling bit 0, the block SHALL register the full 10-bit word to rx_data and set rx_valid=1 for exactly one cycle.
REQ-015 After bit 0, further MOSI bits SHALL be ignored until SS_n rises, and rx_valid SHALL NOT be asserted a second time within the frame.
REQ-016 Completion of a READ_ADD frame SHALL set rd_addr_seen=1, and completion of a READ_DATA frame SHALL clear it.
REQ-017 In READ_DATA, after rx_valid, the first cycle with tx_valid=1 SHALL load tx_data into an 8-bit shift register.
REQ-018 After the tx_data load, MISO SHALL present bit 7 on the following cycle and then one bit per cycle down to bit 0 (8 cycles total).
REQ-019 MISO SHALL be 0 whenever no read byte is being shifted.
REQ-020 SS_n=1 in any non-IDLE state SHALL force IDLE on the next edge, abort any shift in progress, leave rd_addr_seen unchanged for an incomplete frame, and issue no rx_valid.
REQ-021 The same edge that samples bit 0 SHALL generate rx_valid even if SS_n rises simultaneously at that edge.
REQ-022 tx_valid SHALL be ignored outside READ_DATA and after the read byte has been loaded.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, rd_addr_seen=0, bit counter=0, shift registers=0, rx_data=0, rx_valid=0 and MISO=0.
REQ-024 Reset mid-frame SHALL discard the partial frame, and after release the block SHALL wait for a fresh SS_n falling sequence before starting a new frame.

Configuration
REQ-025 The macro SPI_FRAME_ERR_EN, when defined, SHALL add the output frame_err (1 bit) after tx_valid.
REQ-026 With SPI_FRAME_ERR_EN defined, frame_err SHALL pulse for one cycle when SS_n rises before bit 0 of a frame has been sampled, and SHALL reset to 0.
REQ-027 Without SPI_FRAME_ERR_EN, the frame_err port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-028 The bench SHALL cover a write-address frame: SS_n low, MOSI=00_1010_0101 -> rx_data=0x0A5 and a single rx_valid pulse, rd_addr_seen unchanged.
REQ-029 The bench SHALL cover a write-data frame: MOSI=01_0011_1100 -> rx_data=0x13C and the FSM passing through WRITE.
REQ-030 The bench SHALL cover a read sequence: frame 10_0000_0111 -> READ_ADD and rx_data=0x207; then frame 11_xxxx_xxxx with tx_data=0x96 and tx_valid -> READ_DATA, and MISO=1,0,0,1,0,1,1,0 on consecutive cycles.
REQ-031 The bench SHALL cover an aborted frame: SS_n rises after 5 bits -> IDLE, no rx_valid, frame_err=1 for one cycle if SPI_FRAME_ERR_EN is defined.
REQ-032 The bench SHALL cover reset mid-frame: rst_n low during bit 4 -> all outputs 0 at once; a subsequent full 00_0000_0001 frame yields rx_data=0x001.
REQ-033 The bench SHALL cover simultaneous events: SS_n rises at the same edge that samples bit 0 -> rx_valid asserted, and the FSM returns to IDLE on that edge.
